// File: rtl/rank_cmd_arbiter.sv
// rank_cmd_arbiter
// Grants the shared CMD bus to one of NUM_RANK rank controllers. A rank whose
// wait-age has hit AGE_LIMIT takes priority (lowest index first). Otherwise the
// rank with the deepest queue in the current channel mode wins, and depth ties
// rotate round-robin from the rank after the last one served. A switch to a
// different rank after an ack inserts TRTR dead cycles, then one IDLE
// arbitration cycle, before the new grant appears.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   ready_rd / ready_wr        per-rank read / write ready
//   fsm_wait                   per-rank "blocked on timing", masks readiness
//   rd_cnt / wr_cnt            packed per-rank queue depths, rank i at [i*CNT_W +: CNT_W]
//   write_mode                 1 = write mode (use ready_wr / wr_cnt)
//   grant_ack                  granted rank issued its command
//   grant                      one-hot CMD bus grant (registered)
//   grant_valid                OR of grant
//   rank_transition            one-cycle pulse when grant lands on a new rank
//   starve_grant               current grant came from the age rule
module rank_cmd_arbiter #(
    parameter int unsigned NUM_RANK  = 4,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned AGE_LIMIT = 15,
    parameter int unsigned TRTR      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_RANK-1:0]       ready_rd,
    input  logic [NUM_RANK-1:0]       ready_wr,
    input  logic [NUM_RANK-1:0]       fsm_wait,
    input  logic [NUM_RANK*CNT_W-1:0] rd_cnt,
    input  logic [NUM_RANK*CNT_W-1:0] wr_cnt,
    input  logic                      write_mode,
    input  logic                      grant_ack,
    output logic [NUM_RANK-1:0]       grant,
    output logic                      grant_valid,
    output logic                      rank_transition,
    output logic                      starve_grant
);

    localparam int unsigned RW = (NUM_RANK > 1) ? $clog2(NUM_RANK) : 1;
    localparam logic [CNT_W-1:0] AGE_MAX  = '1;
    localparam logic [CNT_W-1:0] AGE_LIM  = CNT_W'(AGE_LIMIT);
    localparam logic [RW-1:0]    LAST_RST = RW'(NUM_RANK - 1);
    localparam logic [3:0]       TRTR_V   = 4'(TRTR);

    typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

    state_e                state_q, state_d;
    logic [NUM_RANK-1:0]   grant_q, grant_d;
    logic                  starve_q, starve_d;
    logic                  trans_q, trans_d;
    logic [RW-1:0]         last_q, last_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  mode_q, mode_d;   // channel mode the current grant was made in
    logic                  seen_q, seen_d;   // a grant has been made since reset
    logic [CNT_W-1:0]      age_q [NUM_RANK];
    logic [CNT_W-1:0]      age_d [NUM_RANK];

    logic [NUM_RANK-1:0]   avail;
    logic [CNT_W-1:0]      depth [NUM_RANK];
    logic                  win_valid;
    logic                  win_starve;
    logic [RW-1:0]         win_idx;
    logic [CNT_W-1:0]      best_depth;
    logic [RW-1:0]         rr;
    int                    rr_sum;
    logic [RW-1:0]         gidx;
    logic                  load;
    logic                  ack_clr;

    // Eligibility and per-rank depth in the current mode.
    always_comb begin
        avail = (write_mode ? ready_wr : ready_rd) & ~fsm_wait;
        for (int i = 0; i < int'(NUM_RANK); i++) begin
            depth[i] = write_mode ? wr_cnt[i*CNT_W +: CNT_W] : rd_cnt[i*CNT_W +: CNT_W];
        end
    end

    // Winner: starved ranks first, else deepest queue with round-robin tie-break.
    always_comb begin
        win_valid  = |avail;
        win_starve = 1'b0;
        win_idx    = '0;
        best_depth = '0;
        rr_sum     = 0;
        rr         = '0;
        for (int i = int'(NUM_RANK) - 1; i >= 0; i--) begin
            if (avail[i] && (age_q[i] >= AGE_LIM)) begin
                win_starve = 1'b1;
                win_idx    = RW'(i);
            end
        end
        if (!win_starve) begin
            // Strict '>' keeps the first rank in rotation order on a tie.
            for (int k = 0; k < int'(NUM_RANK); k++) begin
                rr_sum = int'(last_q) + 1 + k;
                if (rr_sum >= int'(NUM_RANK)) begin
                    rr_sum = rr_sum - int'(NUM_RANK);
                end
                rr = RW'(rr_sum);
                if (avail[rr] && ((k == 0) || !(|(avail & rotated_mask(k))) ||
                                  (depth[rr] > best_depth))) begin
                    win_idx    = rr;
                    best_depth = depth[rr];
                end
            end
        end
    end

    // Mask of ranks visited before step k of the rotation; a rank at step k is
    // taken unconditionally when none of the earlier ones was eligible.
    function automatic logic [NUM_RANK-1:0] rotated_mask(input int k);
        logic [NUM_RANK-1:0] m;
        int                  idx;
        m = '0;
        for (int j = 0; j < int'(NUM_RANK); j++) begin
            idx = int'(last_q) + 1 + j;
            if (idx >= int'(NUM_RANK)) begin
                idx = idx - int'(NUM_RANK);
            end
            if (j < k) begin
                m[idx] = 1'b1;
            end
        end
        return m;
    endfunction

    always_comb begin
        gidx = '0;
        for (int i = 0; i < int'(NUM_RANK); i++) begin
            if (grant_q[i]) begin
                gidx = RW'(i);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        starve_d = starve_q;
        trans_d  = 1'b0;
        last_d   = last_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        seen_d   = seen_q;
        load     = 1'b0;
        ack_clr  = 1'b0;

        case (state_q)
            StIdle: begin
                if (win_valid) begin
                    load = 1'b1;
                end
            end
            StGrant: begin
                if (grant_ack) begin
                    last_d  = gidx;
                    ack_clr = 1'b1;
                    if (!win_valid) begin
                        grant_d  = '0;
                        starve_d = 1'b0;
                        state_d  = StIdle;
                    end else if (win_idx != gidx) begin
                        if (TRTR_V != 4'd0) begin
                            grant_d  = '0;
                            starve_d = 1'b0;
                            cnt_d    = TRTR_V;
                            state_d  = StTurn;
                        end else begin
                            load = 1'b1;
                        end
                    end
                end else if (!(|(grant_q & avail)) || (write_mode != mode_q)) begin
                    grant_d  = '0;
                    starve_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            StTurn: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase

        if (load) begin
            grant_d  = NUM_RANK'(1) << win_idx;
            starve_d = win_starve;
            mode_d   = write_mode;
            trans_d  = seen_q && (win_idx != last_d);
            seen_d   = 1'b1;
            state_d  = StGrant;
        end

        for (int i = 0; i < int'(NUM_RANK); i++) begin
            age_d[i] = age_q[i];
            if (ack_clr && grant_q[i]) begin
                age_d[i] = '0;
            end else if (avail[i] && !grant_q[i] && (age_q[i] != AGE_MAX)) begin
                age_d[i] = age_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            starve_q <= 1'b0;
            trans_q  <= 1'b0;
            last_q   <= LAST_RST;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            seen_q   <= 1'b0;
            for (int i = 0; i < int'(NUM_RANK); i++) begin
                age_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            starve_q <= starve_d;
            trans_q  <= trans_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            seen_q   <= seen_d;
            for (int i = 0; i < int'(NUM_RANK); i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    // Outputs.
    always_comb begin
        grant           = grant_q;
        grant_valid     = |grant_q;
        rank_transition = trans_q;
        starve_grant    = starve_q;
    end

endmodule

// File: tb/tb_rank_cmd_arbiter.sv
module tb_rank_cmd_arbiter;

    localparam int NR = 4;
    localparam int CW = 4;
    localparam int AL = 7;
    localparam int TT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] ready_rd, ready_wr, fsm_wait;
    logic [NR*CW-1:0] rd_cnt, wr_cnt;
    logic          write_mode, grant_ack;
    logic [NR-1:0] grant;
    logic          grant_valid, rank_transition, starve_grant;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: granted rank as an index (-1 = none).
    int m_state;     // 0 idle, 1 grant, 2 turnaround
    int m_g;
    int m_age [NR];
    int m_last;
    int m_cnt;
    bit m_mode, m_seen, m_trans, m_starve;

    rank_cmd_arbiter #(
        .NUM_RANK (NR),
        .CNT_W    (CW),
        .AGE_LIMIT(AL),
        .TRTR     (TT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ready_rd       (ready_rd),
        .ready_wr       (ready_wr),
        .fsm_wait       (fsm_wait),
        .rd_cnt         (rd_cnt),
        .wr_cnt         (wr_cnt),
        .write_mode     (write_mode),
        .grant_ack      (grant_ack),
        .grant          (grant),
        .grant_valid    (grant_valid),
        .rank_transition(rank_transition),
        .starve_grant   (starve_grant)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int depth_of(input int r);
        logic [NR*CW-1:0] v;
        v = write_mode ? wr_cnt : rd_cnt;
        return int'((v >> (CW * r)) & 16'hF);
    endfunction

    function automatic int m_winner(input logic [NR-1:0] av, output bit by_age);
        int best, r;
        best   = -1;
        by_age = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (best < 0 && av[i] && m_age[i] >= AL) begin
                best   = i;
                by_age = 1'b1;
            end
        end
        if (!by_age) begin
            for (int k = 1; k <= NR; k++) begin
                r = (m_last + k) % NR;
                if (av[r] && (best < 0 || depth_of(r) > depth_of(best))) best = r;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_state = 0; m_g = -1; m_last = NR - 1; m_cnt = 0;
        m_mode = 0; m_seen = 0; m_trans = 0; m_starve = 0;
        for (int i = 0; i < NR; i++) m_age[i] = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        logic [NR-1:0] av;
        int w, new_last;
        bit sa, load;
        if (rst) begin
            model_reset();
            return;
        end
        av       = (write_mode ? ready_wr : ready_rd) & ~fsm_wait;
        w        = m_winner(av, sa);
        new_last = m_last;
        load     = 1'b0;
        m_trans  = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (m_state == 1 && grant_ack && m_g == i) m_age[i] = 0;
            else if (av[i] && m_g != i && m_age[i] < 15) m_age[i]++;
        end
        case (m_state)
            0: if (w >= 0) load = 1'b1;
            1: begin
                if (grant_ack) begin
                    new_last = m_g;
                    if (w < 0) begin
                        m_g = -1; m_state = 0;
                    end else if (w != m_g) begin
                        if (TT > 0) begin
                            m_g = -1; m_state = 2; m_cnt = TT;
                        end else begin
                            load = 1'b1;
                        end
                    end
                end else if (!av[m_g] || write_mode != m_mode) begin
                    m_g = -1; m_state = 0;
                end
            end
            default: begin
                m_cnt--;
                if (m_cnt == 0) m_state = 0;
            end
        endcase
        if (load) begin
            m_trans  = m_seen && (w != new_last);
            m_seen   = 1'b1;
            m_g      = w;
            m_starve = sa;
            m_mode   = write_mode;
            m_state  = 1;
        end
        if (m_g < 0) m_starve = 1'b0;
        m_last = new_last;
    endtask

    task automatic cycle();
        logic [31:0] exp_g;
        model_step();
        @(posedge clk);
        #1;
        exp_g = (m_g < 0) ? 32'd0 : (32'd1 << m_g);
        check_eq("grant", {28'd0, grant}, exp_g);
        check_eq("grant_valid", {31'd0, grant_valid}, {31'd0, m_g >= 0});
        check_eq("rank_transition", {31'd0, rank_transition}, {31'd0, m_trans});
        check_eq("starve_grant", {31'd0, starve_grant}, {31'd0, m_starve});
        check_eq("onehot", {31'd0, $onehot0(grant)}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1; grant_ack = 1'b0;
        cycle();
        check_eq("rst_grant", {28'd0, grant}, 32'd0);
        check_eq("rst_trans", {31'd0, rank_transition}, 32'd0);
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ready_rd = '0; ready_wr = '0; fsm_wait = '0;
        rd_cnt = '0; wr_cnt = '0; write_mode = 1'b0; grant_ack = 1'b0;
        model_reset();
        do_reset();

        // Max depth: rank1 has the deepest read queue.
        ready_rd = 4'b1111; rd_cnt = {4'd1, 4'd5, 4'd9, 4'd3};
        cycle();
        check_eq("maxdepth_grant", {28'd0, grant}, 32'b0010);
        check_eq("maxdepth_starve", {31'd0, starve_grant}, 32'd0);
        check_eq("maxdepth_trans", {31'd0, rank_transition}, 32'd0);

        // Reset during an active grant; first grant afterwards must not pulse.
        do_reset();
        ready_rd = 4'b0010;
        cycle();
        check_eq("post_rst_grant", {28'd0, grant}, 32'b0010);
        check_eq("post_rst_trans", {31'd0, rank_transition}, 32'd0);
        // Ack with nothing else eligible: last_rank becomes 1, back to idle.
        ready_rd = 4'b0000; grant_ack = 1'b1;
        cycle();
        grant_ack = 1'b0;

        // Tie: all depth 4, rotation starts after rank1.
        ready_rd = 4'b1111; rd_cnt = {4'd4, 4'd4, 4'd4, 4'd4};
        cycle();
        check_eq("tie_grant", {28'd0, grant}, 32'b0100);
        check_eq("tie_trans", {31'd0, rank_transition}, 32'd1);
        rd_cnt = {4'd9, 4'd4, 4'd4, 4'd4}; grant_ack = 1'b1;
        cycle();
        grant_ack = 1'b0;
        check_eq("turn1_grant", {28'd0, grant}, 32'd0);
        cycle();
        check_eq("turn2_grant", {28'd0, grant}, 32'd0);
        cycle();
        check_eq("idle_grant", {28'd0, grant}, 32'd0);
        cycle();
        check_eq("switch_grant", {28'd0, grant}, 32'b1000);
        check_eq("switch_trans", {31'd0, rank_transition}, 32'd1);

        // Starvation: rank3 deep and acked every time, rank0 shallow.
        do_reset();
        ready_rd = 4'b1001; rd_cnt = {4'd8, 4'd0, 4'd0, 4'd1};
        for (int c = 0; c < 40 && m_g != 0; c++) begin
            grant_ack = (m_g == 3);
            cycle();
        end
        grant_ack = 1'b0;
        check_eq("starve_rank", {28'd0, grant}, 32'b0001);
        check_eq("starve_flag", {31'd0, starve_grant}, 32'd1);

        // Revoke: granted rank2 starts waiting on timing.
        do_reset();
        ready_rd = 4'b1111; rd_cnt = {4'd3, 4'd9, 4'd2, 4'd1};
        cycle();
        check_eq("revoke_pre", {28'd0, grant}, 32'b0100);
        fsm_wait = 4'b0100;
        cycle();
        check_eq("revoke_grant", {28'd0, grant}, 32'd0);
        check_eq("revoke_trans", {31'd0, rank_transition}, 32'd0);
        cycle();
        check_eq("revoke_rearb", {28'd0, grant}, 32'b1000);
        fsm_wait = 4'b0000;

        // Mode flip without ack.
        do_reset();
        ready_rd = 4'b1111; ready_wr = 4'b1111;
        rd_cnt = {4'd1, 4'd1, 4'd1, 4'd5}; wr_cnt = {4'd6, 4'd1, 4'd1, 4'd1};
        cycle();
        cycle();
        check_eq("mode_hold", {28'd0, grant}, 32'b0001);
        write_mode = 1'b1;
        cycle();
        check_eq("mode_revoke", {28'd0, grant}, 32'd0);
        cycle();
        check_eq("mode_rearb", {28'd0, grant}, 32'b1000);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            ready_rd  = 4'($urandom);
            ready_wr  = 4'($urandom);
            fsm_wait  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            if ($urandom_range(0, 3) == 0) rd_cnt = 16'($urandom);
            if ($urandom_range(0, 3) == 0) wr_cnt = 16'($urandom);
            if ($urandom_range(0, 19) == 0) write_mode = ~write_mode;
            grant_ack = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
